// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between CPU fetch (IF) and memory (D) stages; D has fixed priority.
// Define MEM_ARB_FAIR_EN to let IF win one slot after STARVE_MAX consecutive D grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("mem_port_arbiter: RD_LAT must be 1..4");
    end
    if (STARVE_MAX > 7) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must fit the 3-bit counter");
    end

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] own_q, own_d;   // 1 = D owns the read, 0 = IF
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_win;
    logic              rd_gnt;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    logic [2:0] starve_q, starve_d;

    assign if_win = (starve_q == STARVE_LIM) && if_req && d_req;

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (d_gnt && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_win = 1'b0;
`endif

    // Grants are suppressed during reset so every output reads 0 while it is held.
    assign d_gnt  = !reset && d_req && !if_win;
    assign if_gnt = !reset && if_req && !d_gnt;
    assign mem_en = d_gnt || if_gnt;
    assign mem_we = (d_gnt && d_we) ? d_wstrb : '0;
    assign rd_gnt = if_gnt || (d_gnt && !d_we);

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        vld_d = (vld_q << 1) | RD_LAT'(rd_gnt);
        own_d = (own_q << 1) | RD_LAT'(d_gnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            own_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

    assign if_rvalid = !reset && vld_q[RD_LAT-1] && !own_q[RD_LAT-1];
    assign d_rvalid  = !reset && vld_q[RD_LAT-1] &&  own_q[RD_LAT-1];
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;
    assign busy      = !reset && (|vld_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural RD_LAT-cycle RAM attached.
module tb_mem_port_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [3:0]    d_wstrb;
    logic          mem_en, busy;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data appears LAT cycles after the enable cycle.
    logic [31:0] ram [0:255];
    logic [31:0] rpipe [LAT];
    assign mem_rdata = rpipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= ram[mem_addr[7:0]];
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t ifq[$];
    exp_t dq[$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitor: every rvalid must match the oldest outstanding expectation for that port.
    always @(negedge clk) begin
        exp_t e;
        if (if_rvalid) begin
            if (ifq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL if_unexpected_rvalid: got rdata 0x%0h, expected no response (cycle %0d)", if_rdata, cyc);
            end else begin
                e = ifq.pop_front();
                check("if_rdata", 64'(if_rdata), 64'(e.data));
                check("if_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (d_rvalid) begin
            if (dq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL d_unexpected_rvalid: got rdata 0x%0h, expected no response (cycle %0d)", d_rdata, cyc);
            end else begin
                e = dq.pop_front();
                check("d_rdata", 64'(d_rdata), 64'(e.data));
                check("d_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // One cycle: check grant-cycle outputs at negedge, queue expected read data, advance.
    task automatic tick(input bit eig, input bit edg, input logic [31:0] edata,
                        input logic [3:0] ewe, input bit resp);
        @(negedge clk);
        check("if_gnt", 64'(if_gnt), 64'(eig));
        check("d_gnt", 64'(d_gnt), 64'(edg));
        check("mem_en", 64'(mem_en), 64'(eig | edg));
        check("mem_we", 64'(mem_we), 64'(ewe));
        if (edg) check("mem_addr_d", 64'(mem_addr), 64'(d_addr));
        else if (eig) check("mem_addr_if", 64'(mem_addr), 64'(if_addr));
        if (edg && d_we) check("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
        if (resp && eig) ifq.push_back('{edata, cyc + LAT});
        if (resp && edg && !d_we) dq.push_back('{edata, cyc + LAT});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA5000000 | i;
        ram[8'h08] = 32'h0;
        ram[8'h10] = 32'hDEADBEEF;
        ram[8'h14] = 32'h01234567;
        ram[8'h20] = 32'hCAFEF00D;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = '0; d_wstrb = '0;

        // Reset held with both requesting: everything must stay at 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ctrl", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy, mem_we}), 64'h0);
            check("reset_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
            check("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1'b0, 1'b1, 32'hCAFEF00D, 4'h0, 1'b1);   // first post-reset grant goes to D
        d_req = 1'b0;
        tick(1'b1, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1);   // IF retries
        idle(4);

        // Plain IF read, then busy while in flight.
        if_req = 1'b1; if_addr = 32'h10;
        tick(1'b1, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1);
        if_req = 1'b0;
        @(negedge clk);
        check("busy_inflight", 64'(busy), 64'h1);
        @(posedge clk); #1;
        idle(3);

        // Contention: D read 0x20 and IF read 0x14 together.
        if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_addr = 32'h20;
        tick(1'b0, 1'b1, 32'hCAFEF00D, 4'h0, 1'b1);
        d_req = 1'b0;
        tick(1'b1, 1'b0, 32'h01234567, 4'h0, 1'b1);
        idle(3);

        // Partial byte write, readback, then zero-strobe write that must not alter RAM.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h11223344; d_wstrb = 4'b0011;
        tick(1'b0, 1'b1, 32'h0, 4'b0011, 1'b1);
        d_we = 1'b0;
        tick(1'b0, 1'b1, 32'h00003344, 4'h0, 1'b1);
        d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'b0000;
        tick(1'b0, 1'b1, 32'h0, 4'h0, 1'b1);
        d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        tick(1'b1, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1);
        idle(3);

        // Reset while an IF read is in flight: the response must vanish.
        if_req = 1'b1; if_addr = 32'h14;
        tick(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        if_req = 1'b0; reset = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("busy_after_reset", 64'(busy), 64'h0);
        check("if_rvalid_after_reset", 64'(if_rvalid), 64'h0);
        @(posedge clk); #1;
        idle(3);

        // Both requesting continuously.
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
`ifdef MEM_ARB_FAIR_EN
        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 4) tick(1'b1, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1);
            else            tick(1'b0, 1'b1, 32'hCAFEF00D, 4'h0, 1'b1);
        end
`else
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, 32'hCAFEF00D, 4'h0, 1'b1);
`endif
        idle(LAT + 3);

        check("if_queue_drained", 64'(ifq.size()), 64'h0);
        check("d_queue_drained", 64'(dq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
